spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI slave endpoint: the responder for the team's spi_master, so two boards or two FPGA blocks can exchange one d_width-bit word per ss_n assertion.
- Pins sclk, ss_n and mosi are asynchronous to clk. They pass through 2-flop synchronizers, and edges are detected in the clk domain (oversampling slave).
- Supports all four cpol/cpha modes with MSB-first shifting, matching the master.
- Sits between the wb_spi register wrapper and the pads. Software loads a tx word and reads the rx word on the rx_valid pulse.

Parameters:
- d_width, 8: word width in bits; minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cpol  input  1  sclk idle level; latched at frame start.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start.
- tx_data  input  d_width  word to transmit in the next frame.
- tx_load  input  1  1-cycle strobe; copies tx_data into tx_hold.
- sclk  input  1  SPI clock from master, asynchronous.
- ss_n  input  1  slave select, active low, asynchronous.
- mosi  input  1  serial data from master, asynchronous.
- miso  output  1  serial data to master; 1 when not selected.
- rx_data  output  d_width  last complete received word.
- rx_valid  output  1  1-cycle pulse when rx_data updates.
- busy  output  1  high while a frame is in progress (state not IDLE).
- frame_err  output  1  1-cycle pulse when ss_n rises before d_width bits have been sampled.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - Outputs: miso=1, rx_data=0, rx_valid=0, busy=0, frame_err=0.
  - Internal: tx_hold=0, bit_cnt=0, state=IDLE.
  - Synchronizers: ss_n sync chain=1, sclk sync chain=cpol.
  - Reset mid-frame aborts the frame; no rx_valid and no frame_err.
- Synchronization: 3-stage chain per input. Stages 1-2 are metastability protection; edge = stage2 vs stage3. Sampled mosi = stage2.
  - Constraint: sclk high and low times are each >= 3 clk periods; spi_master clk_div >= 3 satisfies this.
- Edge selection, using cpol/cpha latched at ss_n fall:
  - Sample edge is rising when cpol==cpha, falling otherwise.
  - Shift edge is the opposite edge.
- tx_hold:
  - tx_load=1 loads tx_data at any time.
  - Mid-frame loads affect only the next frame.
- State machine:
  - IDLE: miso=1, busy=0. On detected ss_n fall: latch cpol/cpha, tx_shift<=tx_hold (or tx_data if tx_load in the same cycle), bit_cnt<=0, go ACTIVE.
    - If cpha=0: miso<=tx_hold[MSB] and tx_shift shifts left in that same cycle.
  - ACTIVE:
    - Sample edge: rx_shift<={rx_shift[d_width-2:0], mosi_s}; bit_cnt++.
    - When bit_cnt==d_width-1 on a sample edge: rx_data<={rx_shift[d_width-2:0], mosi_s}, rx_valid=1 next cycle, go DONE.
    - Shift edge: miso<=tx_shift[MSB]; tx_shift<<=1. For cpha=0 this continues from bit d_width-2.
    - ss_n rise detected: frame_err pulse, miso<=1, go IDLE; rx_data unchanged.
  - DONE: all sclk edges ignored; miso holds. On ss_n rise: miso<=1, go IDLE, no frame_err.
- Latency: rx_valid is high exactly one clk after the cycle in which the final sample edge is detected, i.e. 3-4 clk after the pin edge.
- Simultaneous events:
  - ss_n rise detected in the same cycle as the final sample edge: the word completes, rx_valid fires, no frame_err.
  - Sclk edges while ss_n is high are ignored.
- Extra master toggles after d_width bits are harmless because DONE ignores them.

Test Plan:
1. Mode 0 (cpol=0, cpha=0), tx_load 0xA5, master sends 0x3C with clk_div=4 -> rx_data=0x3C with one rx_valid pulse; master receives 0xA5; miso=1 after ss_n rise.
2. Repeat in modes 1, 2 and 3 with tx 0x81 / rx 0x7E -> correct bytes both ways in every mode; busy high from ss_n fall until after the rise.
3. Short frame: ss_n deasserted after 5 sample edges -> frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value.
4. tx_load 0x55 mid-frame while sending 0xAA -> current frame returns 0xAA; next frame returns 0x55.
5. rst asserted mid-frame at bit 3 -> next clk: busy=0, miso=1, rx_data=0, no pulses; the next full frame works normally.
6. Two back-to-back frames with 3 clk of ss_n high between them -> two rx_valid pulses carrying the correct words.

Source files
------------

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Oversampling SPI slave endpoint that answers the team's spi_master. One
// d_width-bit word is exchanged MSB-first per ss_n assertion, in any of the
// four cpol/cpha modes. The SPI pins are asynchronous to clk: they are
// synchronized and their edges detected in the clk domain, so the sclk high
// and low times must each be at least 3 clk periods.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   cpol       sclk idle level, captured when a frame starts
//   cpha       0: sample on leading edge, 1: sample on trailing edge
//              (captured when a frame starts)
//   tx_data    word to send in the next frame
//   tx_load    1-cycle strobe, copies tx_data into the tx holding register
//   sclk       SPI clock from the master (asynchronous)
//   ss_n       slave select, active low (asynchronous)
//   mosi       serial data from the master (asynchronous)
//   miso       serial data to the master, 1 while not selected
//   rx_data    last complete received word
//   rx_valid   1-cycle pulse when rx_data updates
//   busy       high while a frame is in progress
//   frame_err  1-cycle pulse when ss_n rises before a full word was sampled
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int d_width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [d_width-1:0] tx_data,
    input  logic               tx_load,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    output logic               busy,
    output logic               frame_err
);

    localparam int cnt_w = (d_width > 2) ? $clog2(d_width) : 1;
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(d_width - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Synchronizer chains: bit 0 is stage 1, bit 2 is stage 3. Edges are
    // taken between stage 2 and stage 3. mosi is only ever sampled (never
    // edge-detected), so its stage 2 is the last flop it needs.
    logic [2:0] sclk_sync;
    logic [2:0] ss_sync;
    logic [1:0] mosi_sync;

    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;
    logic mosi_s;

    logic mode_cpol;
    logic mode_cpha;
    logic sample_edge;
    logic shift_edge;

    logic [d_width-1:0] tx_hold;
    logic [d_width-1:0] tx_shift;
    logic [d_width-1:0] rx_shift;
    logic [d_width-1:0] load_word;
    logic [cnt_w-1:0]   bit_cnt;

    logic start_frame;
    logic do_sample;
    logic do_shift;
    logic finish_word;
    logic abort_frame;
    logic release_bus;

    // The sclk chain resets to the current idle level so that no phantom
    // edge appears right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {3{cpol}};
            ss_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            ss_sync   <= {ss_sync[1:0], ss_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign mosi_s    = mosi_sync[1];

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling
    // edge; data is shifted out on the other edge.
    assign sample_edge = (mode_cpol == mode_cpha) ? sclk_rise : sclk_fall;
    assign shift_edge  = (mode_cpol == mode_cpha) ? sclk_fall : sclk_rise;

    // A load strobe coinciding with the frame start must still make it into
    // the frame, so bypass the holding register in that case.
    assign load_word = tx_load ? tx_data : tx_hold;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control. A final sample edge wins over a
    // simultaneous ss_n rise so the word still completes without an error;
    // in that case the bus is released directly since the rise is already
    // consumed.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        finish_word = 1'b0;
        abort_frame = 1'b0;
        release_bus = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    start_frame = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    do_sample = 1'b1;
                    if (bit_cnt == last_bit) begin
                        finish_word = 1'b1;
                        state_next  = DONE;
                    end
                end else if (shift_edge) begin
                    do_shift = 1'b1;
                end
                if (ss_rise) begin
                    release_bus = 1'b1;
                    state_next  = IDLE;
                    if (!finish_word) begin
                        abort_frame = 1'b1;
                        do_sample   = 1'b0;
                        do_shift    = 1'b0;
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    release_bus = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With cpha=0 the first bit must already be on miso before the first
    // (sampling) edge, so it is presented at frame start and the shift
    // register continues from the second bit on the shift edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso      <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            tx_hold   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            mode_cpol <= 1'b0;
            mode_cpha <= 1'b0;
        end else begin
            rx_valid  <= finish_word;
            frame_err <= abort_frame;

            if (tx_load) begin
                tx_hold <= tx_data;
            end

            if (start_frame) begin
                mode_cpol <= cpol;
                mode_cpha <= cpha;
                bit_cnt   <= '0;
                if (!cpha) begin
                    miso     <= load_word[d_width-1];
                    tx_shift <= {load_word[d_width-2:0], 1'b0};
                end else begin
                    tx_shift <= load_word;
                end
            end

            if (do_sample) begin
                rx_shift <= {rx_shift[d_width-2:0], mosi_s};
                bit_cnt  <= bit_cnt + cnt_w'(1);
            end

            if (finish_word) begin
                rx_data <= {rx_shift[d_width-2:0], mosi_s};
            end

            if (do_shift) begin
                miso     <= tx_shift[d_width-1];
                tx_shift <= {tx_shift[d_width-2:0], 1'b0};
            end

            if (release_bus) begin
                miso <= 1'b1;
            end
        end
    end

endmodule
